// File: rtl/exec_stage_p_if.sv
// Execute-stage request/result bundle: operands, op selects, handshake and status.
// The master side (operand fetch) drives requests; the slave side (exec_stage_p) returns results.
interface exec_stage_p_if #(
  parameter int unsigned WIDTH = 16
);
  logic             InValid;
  logic [WIDTH-1:0] ALUInA;
  logic [WIDTH-1:0] ALUInB;
  logic [2:0]       ALUop;
  logic [1:0]       ShiftOp;
  logic             ResSource;
  logic             ResWrite;
  logic             Flush;
  logic [WIDTH-1:0] ResOut;
  logic             ResValid;
  logic             Busy;
  logic             isZero;
  logic             Carry;
  logic             Overflow;

  modport master (
    output InValid, ALUInA, ALUInB, ALUop, ShiftOp, ResSource, ResWrite, Flush,
    input  ResOut, ResValid, Busy, isZero, Carry, Overflow
  );

  modport slave (
    input  InValid, ALUInA, ALUInB, ALUop, ShiftOp, ResSource, ResWrite, Flush,
    output ResOut, ResValid, Busy, isZero, Carry, Overflow
  );
endinterface

// File: rtl/exec_stage_p.sv
// Execute stage: WIDTH-bit ALU plus shift unit feeding a registered result with status flags.
// Build option EXEC_BARREL_SHIFT_EN: single-cycle barrel shifter (Busy tied 0, no SHIFT state).
// Default build: iterative shifter, one bit position per cycle, Busy while shifting.
module exec_stage_p #(
  parameter int unsigned WIDTH = 16
) (
  input logic        CLK,
  input logic        RST_N,
  exec_stage_p_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] a, b;
  logic [SHW-1:0]   shamt;
  logic             accept;

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   sum_w, dif_w;

  logic             commit, commit_wr;
  logic [WIDTH-1:0] c_res;
  logic             c_c, c_v;

  assign a     = bus.ALUInA;
  assign b     = bus.ALUInB;
  assign shamt = bus.ALUInB[SHW-1:0];

`ifdef EXEC_BARREL_SHIFT_EN
  logic [2*WIDTH-1:0] rol_w;
  logic [WIDTH-1:0]   bsh_res;

  assign bus.Busy = 1'b0;
  assign accept   = bus.InValid & ~bus.Flush;

  // Single-cycle barrel shift of operand A
  always_comb begin
    rol_w   = {a, a} << shamt;
    bsh_res = a;
    case (bus.ShiftOp)
      2'b00:   bsh_res = a << shamt;
      2'b01:   bsh_res = a >> shamt;
      2'b10:   bsh_res = $unsigned($signed(a) >>> shamt);
      default: bsh_res = rol_w[2*WIDTH-1:WIDTH];
    endcase
  end
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [1:0]       sop_q, sop_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] step_res;

  assign bus.Busy = (state_q == StShift);
  assign accept   = bus.InValid & ~bus.Busy & ~bus.Flush;

  // One bit position of the latched shift op applied to the shift register
  always_comb begin
    step_res = sreg_q;
    case (sop_q)
      2'b00:   step_res = {sreg_q[MSB-1:0], 1'b0};
      2'b01:   step_res = {1'b0, sreg_q[MSB:1]};
      2'b10:   step_res = {sreg_q[MSB], sreg_q[MSB:1]};
      default: step_res = {sreg_q[MSB-1:0], sreg_q[MSB]};
    endcase
  end
`endif

  // ALU result and arithmetic flags; SUB carry is the no-borrow bit of A + ~B + 1
  always_comb begin
    sum_w   = {1'b0, a} + {1'b0, b};
    dif_w   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.ALUop)
      3'b000: begin
        alu_res = sum_w[MSB:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
      end
      3'b001: begin
        alu_res = dif_w[MSB:0];
        alu_c   = dif_w[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (dif_w[MSB] != a[MSB]);
      end
      3'b010:  alu_res = a & b;
      3'b011:  alu_res = a | b;
      3'b100:  alu_res = a ^ b;
      3'b101:  alu_res = ~(a | b);
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = b;
    endcase
  end

  // Next-state: flush wins, then accept, then shift progress; commit updates result and flags
  always_comb begin
    res_d     = res_q;
    zero_d    = zero_q;
    carry_d   = carry_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    commit    = 1'b0;
    commit_wr = 1'b0;
    c_res     = '0;
    c_c       = 1'b0;
    c_v       = 1'b0;
`ifndef EXEC_BARREL_SHIFT_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    sop_d     = sop_q;
    wr_d      = wr_q;
`endif
    if (bus.Flush) begin
`ifndef EXEC_BARREL_SHIFT_EN
      state_d = StIdle;
      cnt_d   = '0;
`endif
    end else if (accept) begin
      if (!bus.ResSource) begin
        commit    = 1'b1;
        commit_wr = bus.ResWrite;
        c_res     = alu_res;
        c_c       = alu_c;
        c_v       = alu_v;
      end
`ifdef EXEC_BARREL_SHIFT_EN
      else begin
        commit    = 1'b1;
        commit_wr = bus.ResWrite;
        c_res     = bsh_res;
      end
    end
`else
      else if (shamt == '0) begin
        commit    = 1'b1;
        commit_wr = bus.ResWrite;
        c_res     = a;
      end else begin
        sreg_d  = a;
        cnt_d   = shamt;
        sop_d   = bus.ShiftOp;
        wr_d    = bus.ResWrite;
        state_d = StShift;
      end
    end else if (state_q == StShift) begin
      sreg_d = step_res;
      if (cnt_q == SHW'(1)) begin
        commit    = 1'b1;
        commit_wr = wr_q;
        c_res     = step_res;
        state_d   = StIdle;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
`endif
    if (commit) begin
      valid_d = 1'b1;
      if (commit_wr) begin
        res_d   = c_res;
        zero_d  = (c_res == '0);
        carry_d = c_c;
        ovf_d   = c_v;
      end
    end
  end

  // Result, flags and completion pulse registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      res_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

`ifndef EXEC_BARREL_SHIFT_EN
  // Iterative shifter state: FSM, down-counter, shift register and latched op controls
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sreg_q  <= '0;
      sop_q   <= 2'b00;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      sop_q   <= sop_d;
      wr_q    <= wr_d;
    end
  end
`endif

  assign bus.ResOut   = res_q;
  assign bus.ResValid = valid_q;
  assign bus.isZero   = zero_q;
  assign bus.Carry    = carry_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_exec_stage_p.sv
// Randomised self-checking bench for exec_stage_p against an arithmetic reference model.
module tb_exec_stage_p;
  localparam int unsigned W = 16;

  logic CLK = 1'b0;
  logic RST_N;

  exec_stage_p_if #(.WIDTH(W)) bus ();

  exec_stage_p #(.WIDTH(W)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural state as the model sees it
  logic [15:0] m_res;
  logic        m_z, m_c, m_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_res = 16'h0000;
    m_z   = 1'b1;
    m_c   = 1'b0;
    m_v   = 1'b0;
  endtask

  // Result from plain integer arithmetic on the operation's definition
  task automatic model_op(input logic [2:0] aop, input logic [1:0] sop, input logic src,
                          input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic c, output logic v);
    int ia, ib, sa, sb, k, t;
    ia = int'(a);
    ib = int'(b);
    sa = a[15] ? ia - 65536 : ia;
    sb = b[15] ? ib - 65536 : ib;
    k  = ib % 16;
    c  = 1'b0;
    v  = 1'b0;
    t  = 0;
    if (src) begin
      case (sop)
        2'd0:    t = ia << k;
        2'd1:    t = ia >> k;
        2'd2:    t = sa >>> k;
        default: t = (k == 0) ? ia : ((ia << k) | (ia >> (16 - k)));
      endcase
    end else begin
      case (aop)
        3'd0: begin
          t = ia + ib;
          c = (t > 65535);
          v = (sa + sb > 32767) || (sa + sb < -32768);
        end
        3'd1: begin
          t = ia - ib;
          c = (ia >= ib);
          v = (sa - sb > 32767) || (sa - sb < -32768);
        end
        3'd2:    t = ia & ib;
        3'd3:    t = ia | ib;
        3'd4:    t = ia ^ ib;
        3'd5:    t = ~(ia | ib);
        3'd6:    t = (sa < sb) ? 1 : 0;
        default: t = ib;
      endcase
    end
    r = t[15:0];
  endtask

  task automatic drive(input logic valid, input logic [2:0] aop, input logic [1:0] sop,
                       input logic src, input logic wr, input logic [15:0] a,
                       input logic [15:0] b, input logic flush);
    bus.InValid   = valid;
    bus.ALUop     = aop;
    bus.ShiftOp   = sop;
    bus.ResSource = src;
    bus.ResWrite  = wr;
    bus.ALUInA    = a;
    bus.ALUInB    = b;
    bus.Flush     = flush;
  endtask

  // Called at a negedge; returns at the negedge of the ResValid cycle, so ops can run back-to-back
  task automatic run_op(input string tag, input logic [2:0] aop, input logic [1:0] sop,
                        input logic src, input logic wr, input logic [15:0] a,
                        input logic [15:0] b);
    logic [15:0] er;
    logic        ec, ev;
    int          lat;
    model_op(aop, sop, src, a, b, er, ec, ev);
    lat = 0;
`ifndef EXEC_BARREL_SHIFT_EN
    if (src) lat = int'(b) % 16;
`endif
    drive(1'b1, aop, sop, src, wr, a, b, 1'b0);
    @(negedge CLK);
    bus.InValid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      check_eq({tag, ":busy"}, 32'(bus.Busy), 32'd1);
      check_eq({tag, ":early_valid"}, 32'(bus.ResValid), 32'd0);
      // A request while busy must be ignored
      drive(1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), 1'($urandom), 1'b1,
            16'($urandom), 16'($urandom), 1'b0);
      @(negedge CLK);
      bus.InValid = 1'b0;
    end
    check_eq({tag, ":valid"}, 32'(bus.ResValid), 32'd1);
    check_eq({tag, ":busy_done"}, 32'(bus.Busy), 32'd0);
    if (wr) begin
      m_res = er;
      m_z   = (er == 16'h0000);
      m_c   = ec;
      m_v   = ev;
    end
    check_eq({tag, ":res"}, 32'(bus.ResOut), 32'(m_res));
    check_eq({tag, ":zero"}, 32'(bus.isZero), 32'(m_z));
    check_eq({tag, ":carry"}, 32'(bus.Carry), 32'(m_c));
    check_eq({tag, ":ovf"}, 32'(bus.Overflow), 32'(m_v));
  endtask

  task automatic idle_check(input string tag);
    @(negedge CLK);
    check_eq({tag, ":no_repeat_valid"}, 32'(bus.ResValid), 32'd0);
    check_eq({tag, ":idle_busy"}, 32'(bus.Busy), 32'd0);
  endtask

  task automatic flush_drop(input string tag);
    drive(1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'b1);
    @(negedge CLK);
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    check_eq({tag, ":valid"}, 32'(bus.ResValid), 32'd0);
    check_eq({tag, ":res"}, 32'(bus.ResOut), 32'(m_res));
    check_eq({tag, ":zero"}, 32'(bus.isZero), 32'(m_z));
  endtask

  task automatic reset_check(input string tag);
    check_eq({tag, ":res"}, 32'(bus.ResOut), 32'd0);
    check_eq({tag, ":zero"}, 32'(bus.isZero), 32'd1);
    check_eq({tag, ":carry"}, 32'(bus.Carry), 32'd0);
    check_eq({tag, ":ovf"}, 32'(bus.Overflow), 32'd0);
    check_eq({tag, ":busy"}, 32'(bus.Busy), 32'd0);
    check_eq({tag, ":valid"}, 32'(bus.ResValid), 32'd0);
  endtask

  initial begin
    RST_N = 1'b0;
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    reset_check("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    run_op("add_ovf", 3'd0, 2'd0, 1'b0, 1'b1, 16'h7FFF, 16'h0001);
    check_eq("add_ovf:res_const", 32'(bus.ResOut), 32'h8000);
    check_eq("add_ovf:ovf_const", 32'(bus.Overflow), 32'd1);
    idle_check("add_ovf");

    run_op("sub_zero", 3'd1, 2'd0, 1'b0, 1'b1, 16'h1234, 16'h1234);
    check_eq("sub_zero:carry_const", 32'(bus.Carry), 32'd1);
    check_eq("sub_zero:zero_const", 32'(bus.isZero), 32'd1);

    run_op("sra3", 3'd0, 2'd2, 1'b1, 1'b1, 16'h8000, 16'h0003);
    check_eq("sra3:res_const", 32'(bus.ResOut), 32'hF000);
    idle_check("sra3");

`ifndef EXEC_BARREL_SHIFT_EN
    // ROL by 4 aborted in its second busy cycle
    drive(1'b1, 3'd0, 2'd3, 1'b1, 1'b1, 16'h8001, 16'h0004, 1'b0);
    @(negedge CLK);
    bus.InValid = 1'b0;
    check_eq("rol_flush:busy1", 32'(bus.Busy), 32'd1);
    @(negedge CLK);
    check_eq("rol_flush:busy2", 32'(bus.Busy), 32'd1);
    bus.Flush = 1'b1;
    @(negedge CLK);
    bus.Flush = 1'b0;
    check_eq("rol_flush:busy_clr", 32'(bus.Busy), 32'd0);
    check_eq("rol_flush:valid", 32'(bus.ResValid), 32'd0);
    check_eq("rol_flush:res_hold", 32'(bus.ResOut), 32'(m_res));
    run_op("after_flush", 3'd4, 2'd0, 1'b0, 1'b1, 16'h00F0, 16'h0F0F);
`endif

    flush_drop("flush_drop");

    run_op("set3", 3'd0, 2'd0, 1'b0, 1'b1, 16'h0001, 16'h0002);
    run_op("nowrite", 3'd0, 2'd0, 1'b0, 1'b0, 16'h0005, 16'h0005);
    check_eq("nowrite:res_const", 32'(bus.ResOut), 32'h0003);

    // Shift straight into an ALU op with no bubble
    run_op("b2b_sll", 3'd0, 2'd0, 1'b1, 1'b1, 16'h00A5, 16'h0005);
    run_op("b2b_slt", 3'd6, 2'd0, 1'b0, 1'b1, 16'hFFFE, 16'h0001);
    idle_check("b2b");

    // Asynchronous reset in the middle of a shift
    drive(1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 16'hFFFF, 16'h0009, 1'b0);
    @(negedge CLK);
    bus.InValid = 1'b0;
    @(negedge CLK);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    reset_check("mid_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      // Bias operands toward edge values now and then
      case ($urandom_range(0, 7))
        0: ra = 16'h7FFF;
        1: ra = 16'h8000;
        2: rb = ra;
        3: rb = 16'hFFFF;
        default: ;
      endcase
      run_op("rand", 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 7) != 0),
             ra, rb);
      case ($urandom_range(0, 9))
        0: idle_check("rand");
        1: flush_drop("rand_flush");
        default: ;
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
